mms_rx_smd_classifier: RTL and testbench
========================================

Name: mms_rx_smd_classifier

Overview:
- Receive front end of the MAC Merge sublayer, directly upstream of the 802.3br receive-processing state machine.
- Assembles MII nibbles into bytes and generates the byte strobe and receive-valid that the state machine consumes.
- Classifies each byte received before and at the SMD (Pream/S/C/E/V/R/ERR), and decodes cFrameCnt plus the fragment-count byte that follows an SMD-C.

Parameters:
- MAX_PREAMBLE, 15, number of consecutive 0x55 bytes accepted before the next byte is forced to classify as ERR.
- CHECK_RX_ER, 1, when 1 the mii_rx_er signal contributes to smd_err.

Ports:
- clk  in  1  MII receive clock.
- reset_n  in  1  synchronous, active-low reset.
- mii_rxd  in  4  MII receive nibble, low nibble first.
- mii_rx_dv  in  1  MII receive data valid.
- mii_rx_er  in  1  MII receive error.
- r_rx_dv  out  1  rRxDv to the receive state machine.
- r_rx_data  out  8  rRX_DATA, the assembled byte.
- r_byte_ready  out  1  rByteReady, 1-cycle pulse per byte.
- pream  out  1  current byte is 0x55 in the HUNT state.
- smd_s  out  1  current byte is SMD-S0..S3.
- smd_c  out  1  current byte is SMD-C0..C3.
- smd_e  out  1  current byte is SMD-E.
- smd_v  out  1  current byte is SMD-V.
- smd_r  out  1  current byte is SMD-R.
- smd_err  out  1  unrecognised SMD, rx_er, or preamble overrun.
- c_frame_cnt  out  2  frame-count index from SMD-S/C.
- rx_frag_cnt  out  3  fragment count 0..3; 3'b100 means invalid code.
- frag_valid  out  1  rx_frag_cnt updated with the current byte.
- odd_nibble  out  1  frame ended on an odd nibble; sticky until the next rising edge of mii_rx_dv.

Behaviour:
- Reset:
  - All outputs are 0.
  - The state goes to IDLE and the nibble phase to LOW.
- Nibble assembly:
  - The phase is forced LOW on the rising edge of mii_rx_dv.
  - LOW captures mii_rxd into bits [3:0]; HIGH completes the byte with bits [7:4].
  - The byte registers on the cycle after the HIGH nibble, with r_byte_ready=1 for exactly one cycle.
  - Latency is 2 clocks from the low nibble to r_byte_ready.
- r_rx_dv is mii_rx_dv delayed by 2 clocks, so the last r_byte_ready of a frame always sees r_rx_dv=1.
- Odd-nibble end: if mii_rx_dv falls with the phase at HIGH, the half byte is discarded, no strobe is issued, and odd_nibble=1.
- rx_er is latched across both nibbles of a byte.
- State IDLE:
  - On the rising edge of mii_rx_dv, go to HUNT.
- State HUNT (classify every byte):
  - 0x55 gives pream=1 and the preamble counter increments. If the counter would exceed MAX_PREAMBLE, assert smd_err instead and go to DATA.
  - SMD-E 0xD5 gives smd_e=1.
  - SMD-S0/1/2/3 = 0xE6/0x4C/0x7F/0xB3 give smd_s=1 and c_frame_cnt=0/1/2/3.
  - SMD-C0/1/2/3 = 0x61/0x52/0x9E/0x2A give smd_c=1, c_frame_cnt=0..3, and the next state is FRAG.
  - SMD-V 0x07 gives smd_v; SMD-R 0x19 gives smd_r.
  - Any other byte gives smd_err.
  - rx_er during the byte (with CHECK_RX_ER=1) gives smd_err, overriding the byte classification.
  - Any non-0x55 byte other than SMD-C leaves HUNT for DATA.
- State FRAG:
  - The next byte decodes 0xE6/0x4C/0x7F/0xB3 to rx_frag_cnt 0..3, and any other value to 4.
  - frag_valid=1 for this byte; then go to DATA.
- State DATA:
  - All class flags and frag_valid are 0 for the rest of the frame.
  - Bytes pass through unchanged.
- Output holding:
  - Class flags, c_frame_cnt and rx_frag_cnt are registered with r_rx_data and hold until the next r_byte_ready.
  - Exactly one class flag is high per classified byte.
- Falling edge of mii_rx_dv in any state:
  - Return to IDLE after the last byte is emitted.
  - Clear the preamble counter.
  - Clear the flags 2 cycles later, together with r_rx_dv.
- Frame gaps: back-to-back frames with a single idle clock are handled, and the phase re-aligns on each rising edge.
- Reset mid-frame: outputs clear on the next edge. No byte is emitted until a fresh rising edge of mii_rx_dv (a frame already in progress at reset release is ignored).
- Widths: the preamble counter is 4 bits and saturates; there is no wrap.

Decomposition:
- Package mms_smd_pkg holds:
  - the SMD_E, SMD_S[0:3], SMD_C[0:3], SMD_V, SMD_R and PREAMBLE_BYTE constants;
  - the FRAG_CODE[0:3] values;
  - the classifier state enum (IDLE, HUNT, FRAG, DATA).
- Sub-module mii_nibble_assembler holds the phase, byte register, strobe, odd-nibble detection and the rx_er latch. The top level contains the classifier FSM and the decode logic.

Test Plan:
- Seven bytes of 0x55, then 0xD5, then 60 data bytes: pream on 7 strobes, smd_e on the 8th, then flags 0; 68 strobes; r_rx_dv high/low 2 clocks after mii_rx_dv.
- Preamble, then 0x7F, then data: smd_s=1 and c_frame_cnt=2; no further flags.
- Preamble, then 0x52, then 0x7F, then data: smd_c=1 and c_frame_cnt=1; on the next byte frag_valid=1 and rx_frag_cnt=2.
- Preamble, then 0x2A, then 0x11: rx_frag_cnt=4 with frag_valid=1.
- Preamble, then 0x33: smd_err. Separately, mii_rx_er pulsed on the high nibble of a 0xD5 byte gives smd_err=1 and smd_e=0.
- 16 bytes of 0x55: the 16th byte gives smd_err. Separately, a frame of 5 bytes plus one nibble gives 5 strobes and odd_nibble=1. Separately, reset_n low mid-frame gives all outputs 0 on the next clock.

Source files
------------

// File: rtl/mms_smd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mms_smd_pkg: SMD / fragment-count codes and classifier state encoding.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mms_smd_pkg;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SMD_E         = 8'hD5;
   localparam logic [7:0] SMD_V         = 8'h07;
   localparam logic [7:0] SMD_R         = 8'h19;

   // Index 0 is the leftmost element, so SMD_S[0] = 0xE6.
   localparam logic [0:3][7:0] SMD_S     = {8'hE6, 8'h4C, 8'h7F, 8'hB3};
   localparam logic [0:3][7:0] SMD_C     = {8'h61, 8'h52, 8'h9E, 8'h2A};
   localparam logic [0:3][7:0] FRAG_CODE = {8'hE6, 8'h4C, 8'h7F, 8'hB3};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      FRAG = 2'd2,
      DATA = 2'd3
   } smd_state_e;

   // Returns {hit, index} of b within a four-entry code table.
   function automatic logic [2:0] code_lookup(input logic [7:0] b,
                                              input logic [0:3][7:0] tbl);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 0; i < 4; i++) begin
         if (b == tbl[i]) res = {1'b1, 2'(i)};
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mii_nibble_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mii_nibble_assembler: MII nibble-to-byte packing, strobe, rx_dv delay.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mii_nibble_assembler (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] i_mii_rxd,
   input  logic       i_mii_rx_dv,
   input  logic       i_mii_rx_er,
   output logic       o_rise,
   output logic       o_byte_valid,
   output logic [7:0] o_byte_data,
   output logic       o_byte_er,
   output logic       o_dv_d1,
   output logic       o_rx_dv,
   output logic [7:0] o_rx_data,
   output logic       o_byte_ready,
   output logic       o_odd_nibble
);

   logic       r_dv_prev;
   logic       r_armed;
   logic       r_phase;
   logic [3:0] r_lo;
   logic       r_er_lo;
   logic       w_live;

   // r_dv_prev resets high so a frame already running at reset release
   // never looks like a rising edge.
   assign o_rise       = i_mii_rx_dv & ~r_dv_prev;
   assign w_live       = r_armed | o_rise;
   assign o_byte_valid = i_mii_rx_dv & ~o_rise & r_phase & r_armed;
   assign o_byte_data  = {i_mii_rxd, r_lo};
   assign o_byte_er    = r_er_lo | i_mii_rx_er;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_dv_prev    <= 1'b1;
         r_armed      <= 1'b0;
         r_phase      <= 1'b0;
         r_lo         <= 4'h0;
         r_er_lo      <= 1'b0;
         o_dv_d1      <= 1'b0;
         o_rx_dv      <= 1'b0;
         o_rx_data    <= 8'h00;
         o_byte_ready <= 1'b0;
         o_odd_nibble <= 1'b0;
      end else begin
         r_dv_prev    <= i_mii_rx_dv;
         o_dv_d1      <= i_mii_rx_dv & w_live;
         o_rx_dv      <= o_dv_d1;
         o_byte_ready <= o_byte_valid;
         if (o_rise) begin
            r_armed      <= 1'b1;
            o_odd_nibble <= 1'b0;
         end
         if (!i_mii_rx_dv) begin
            r_phase <= 1'b0;
            if (r_phase && r_armed) o_odd_nibble <= 1'b1;
         end else if (o_rise || !r_phase) begin
            r_lo    <= i_mii_rxd;
            r_er_lo <= i_mii_rx_er;
            r_phase <= 1'b1;
         end else begin
            r_phase <= 1'b0;
            if (r_armed) o_rx_data <= o_byte_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mms_rx_smd_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mms_rx_smd_classifier: MAC Merge receive front end, SMD classification. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mms_rx_smd_classifier #(
   parameter int MAX_PREAMBLE = 15,
   parameter bit CHECK_RX_ER  = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] mii_rxd,
   input  logic       mii_rx_dv,
   input  logic       mii_rx_er,
   output logic       r_rx_dv,
   output logic [7:0] r_rx_data,
   output logic       r_byte_ready,
   output logic       pream,
   output logic       smd_s,
   output logic       smd_c,
   output logic       smd_e,
   output logic       smd_v,
   output logic       smd_r,
   output logic       smd_err,
   output logic [1:0] c_frame_cnt,
   output logic [2:0] rx_frag_cnt,
   output logic       frag_valid,
   output logic       odd_nibble
);

   import mms_smd_pkg::*;

   localparam logic [3:0] c_pream_max = 4'(MAX_PREAMBLE);

   logic       w_rise;
   logic       w_byte_valid;
   logic [7:0] w_byte;
   logic       w_byte_er;
   logic       w_dv_d1;
   logic       w_er;
   logic [2:0] w_s_hit;
   logic [2:0] w_c_hit;
   logic [2:0] w_f_hit;

   smd_state_e r_state;
   logic [3:0] r_pream_cnt;

   mii_nibble_assembler u_asm (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_mii_rxd    (mii_rxd),
      .i_mii_rx_dv  (mii_rx_dv),
      .i_mii_rx_er  (mii_rx_er),
      .o_rise       (w_rise),
      .o_byte_valid (w_byte_valid),
      .o_byte_data  (w_byte),
      .o_byte_er    (w_byte_er),
      .o_dv_d1      (w_dv_d1),
      .o_rx_dv      (r_rx_dv),
      .o_rx_data    (r_rx_data),
      .o_byte_ready (r_byte_ready),
      .o_odd_nibble (odd_nibble)
   );

   assign w_er    = CHECK_RX_ER && w_byte_er;
   assign w_s_hit = code_lookup(w_byte, SMD_S);
   assign w_c_hit = code_lookup(w_byte, SMD_C);
   assign w_f_hit = code_lookup(w_byte, FRAG_CODE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_pream_cnt <= 4'd0;
         pream       <= 1'b0;
         smd_s       <= 1'b0;
         smd_c       <= 1'b0;
         smd_e       <= 1'b0;
         smd_v       <= 1'b0;
         smd_r       <= 1'b0;
         smd_err     <= 1'b0;
         c_frame_cnt <= 2'd0;
         rx_frag_cnt <= 3'd0;
         frag_valid  <= 1'b0;
      end else begin
         if (!mii_rx_dv) begin
            r_state     <= IDLE;
            r_pream_cnt <= 4'd0;
         end else if (w_rise) begin
            r_state     <= HUNT;
            r_pream_cnt <= 4'd0;
         end else if (w_byte_valid) begin
            // Every byte re-registers the whole class set alongside r_rx_data.
            pream       <= 1'b0;
            smd_s       <= 1'b0;
            smd_c       <= 1'b0;
            smd_e       <= 1'b0;
            smd_v       <= 1'b0;
            smd_r       <= 1'b0;
            smd_err     <= 1'b0;
            c_frame_cnt <= 2'd0;
            rx_frag_cnt <= 3'd0;
            frag_valid  <= 1'b0;
            case (r_state)
               HUNT: begin
                  r_state <= DATA;
                  if (w_er) begin
                     smd_err <= 1'b1;
                  end else if (w_byte == PREAMBLE_BYTE) begin
                     if (r_pream_cnt >= c_pream_max) begin
                        smd_err <= 1'b1;
                     end else begin
                        pream       <= 1'b1;
                        r_pream_cnt <= r_pream_cnt + 4'd1;
                        r_state     <= HUNT;
                     end
                  end else if (w_byte == SMD_E) begin
                     smd_e <= 1'b1;
                  end else if (w_s_hit[2]) begin
                     smd_s       <= 1'b1;
                     c_frame_cnt <= w_s_hit[1:0];
                  end else if (w_c_hit[2]) begin
                     smd_c       <= 1'b1;
                     c_frame_cnt <= w_c_hit[1:0];
                     r_state     <= FRAG;
                  end else if (w_byte == SMD_V) begin
                     smd_v <= 1'b1;
                  end else if (w_byte == SMD_R) begin
                     smd_r <= 1'b1;
                  end else begin
                     smd_err <= 1'b1;
                  end
               end
               FRAG: begin
                  frag_valid  <= 1'b1;
                  rx_frag_cnt <= w_f_hit[2] ? {1'b0, w_f_hit[1:0]} : 3'b100;
                  r_state     <= DATA;
               end
               default: begin
               end
            endcase
         end
         // Flags drop on the same edge that r_rx_dv falls.
         if (!w_byte_valid && !w_dv_d1) begin
            pream       <= 1'b0;
            smd_s       <= 1'b0;
            smd_c       <= 1'b0;
            smd_e       <= 1'b0;
            smd_v       <= 1'b0;
            smd_r       <= 1'b0;
            smd_err     <= 1'b0;
            c_frame_cnt <= 2'd0;
            rx_frag_cnt <= 3'd0;
            frag_valid  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mms_rx_smd_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mms_rx_smd_classifier: directed frames against a per-byte model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mms_rx_smd_classifier;

   localparam int MAXP = 15;

   typedef struct packed {
      logic [7:0] d;
      logic [6:0] fl;   // {pream, s, c, e, v, r, err}
      logic [1:0] cfc;
      logic [2:0] frag;
      logic       fv;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] mii_rxd = 4'h0;
   logic       mii_rx_dv = 1'b0;
   logic       mii_rx_er = 1'b0;
   logic       r_rx_dv;
   logic [7:0] r_rx_data;
   logic       r_byte_ready;
   logic       pream, smd_s, smd_c, smd_e, smd_v, smd_r, smd_err;
   logic [1:0] c_frame_cnt;
   logic [2:0] rx_frag_cnt;
   logic       frag_valid;
   logic       odd_nibble;

   mms_rx_smd_classifier #(.MAX_PREAMBLE(MAXP), .CHECK_RX_ER(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv),
      .mii_rx_er(mii_rx_er), .r_rx_dv(r_rx_dv), .r_rx_data(r_rx_data),
      .r_byte_ready(r_byte_ready), .pream(pream), .smd_s(smd_s), .smd_c(smd_c),
      .smd_e(smd_e), .smd_v(smd_v), .smd_r(smd_r), .smd_err(smd_err),
      .c_frame_cnt(c_frame_cnt), .rx_frag_cnt(rx_frag_cnt),
      .frag_valid(frag_valid), .odd_nibble(odd_nibble)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] tS [4] = '{8'hE6, 8'h4C, 8'h7F, 8'hB3};
   logic [7:0] tC [4] = '{8'h61, 8'h52, 8'h9E, 8'h2A};

   logic [7:0] fb [$];
   bit         fe [$];
   exp_t       exp_q [$];
   exp_t       held = '0;
   bit         chk_en = 1'b0;

   int t_strobe, t_dvhi, t_pream, t_s, t_c, t_e, t_v, t_r, t_errf, t_fv;
   logic [1:0] last_cfc;
   logic [2:0] last_frag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int find_s(input logic [7:0] b);
      for (int k = 0; k < 4; k++) if (tS[k] == b) return k;
      return -1;
   endfunction

   function automatic int find_c(input logic [7:0] b);
      for (int k = 0; k < 4; k++) if (tC[k] == b) return k;
      return -1;
   endfunction

   // Expected result of every byte of the frame in fb/fe.
   function automatic void build();
      int   mode = 0;   // 0 classifying, 1 fragment byte next, 2 payload
      int   pc = 0;
      int   k;
      exp_t e;
      for (int i = 0; i < fb.size(); i++) begin
         e = '0;
         e.d = fb[i];
         if (mode == 0) begin
            mode = 2;
            if (fe[i]) e.fl = 7'b0000001;
            else if (fb[i] == 8'h55) begin
               if (pc >= MAXP) e.fl = 7'b0000001;
               else begin e.fl = 7'b1000000; pc++; mode = 0; end
            end
            else if (fb[i] == 8'hD5) e.fl = 7'b0001000;
            else if (find_s(fb[i]) >= 0) begin
               e.fl = 7'b0100000; e.cfc = 2'(find_s(fb[i]));
            end
            else if (find_c(fb[i]) >= 0) begin
               e.fl = 7'b0010000; e.cfc = 2'(find_c(fb[i])); mode = 1;
            end
            else if (fb[i] == 8'h07) e.fl = 7'b0000100;
            else if (fb[i] == 8'h19) e.fl = 7'b0000010;
            else e.fl = 7'b0000001;
         end else if (mode == 1) begin
            k = find_s(fb[i]);   // fragment codes share the SMD-S values
            e.fv = 1'b1;
            e.frag = (k >= 0) ? 3'(k) : 3'd4;
            mode = 2;
         end
         exp_q.push_back(e);
      end
   endfunction

   // Per-cycle compare process.
   initial begin
      logic cur, prev_s, exp_dv;
      exp_t x;
      prev_s = 1'b0;
      forever begin
         @(posedge clk);
         cur = reset_n ? mii_rx_dv : 1'b0;
         #1;
         exp_dv = prev_s;
         prev_s = cur;
         if (r_rx_dv) t_dvhi++;
         if (r_byte_ready) begin
            t_strobe++;
            if (pream) t_pream++;
            if (smd_s) t_s++;
            if (smd_c) t_c++;
            if (smd_e) t_e++;
            if (smd_v) t_v++;
            if (smd_r) t_r++;
            if (smd_err) t_errf++;
            if (smd_s || smd_c) last_cfc = c_frame_cnt;
            if (frag_valid) begin t_fv++; last_frag = rx_frag_cnt; end
         end
         if (chk_en) begin
            check("r_rx_dv", 32'(r_rx_dv), 32'(exp_dv));
            if (r_byte_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_strobe", 32'd1, 32'd0);
               end else begin
                  held = exp_q.pop_front();
                  check("r_rx_data", 32'(r_rx_data), 32'(held.d));
               end
            end else if (!exp_dv) begin
               held = '0;
            end
            x = held;
            check("flags_cfc_frag_fv",
                  32'({pream, smd_s, smd_c, smd_e, smd_v, smd_r, smd_err,
                       c_frame_cnt, rx_frag_cnt, frag_valid}),
                  32'({x.fl, x.cfc, x.frag, x.fv}));
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic clr();
      fb.delete();
      fe.delete();
   endtask

   task automatic addb(input logic [7:0] b, input bit er);
      fb.push_back(b);
      fe.push_back(er);
   endtask

   task automatic pre(input int n);
      for (int i = 0; i < n; i++) addb(8'h55, 1'b0);
   endtask

   task automatic data(input int n, input int seed);
      for (int i = 0; i < n; i++) addb(8'((seed + i * 7) & 255), 1'b0);
   endtask

   task automatic zero_tallies();
      t_strobe = 0; t_dvhi = 0; t_pream = 0; t_s = 0; t_c = 0; t_e = 0;
      t_v = 0; t_r = 0; t_errf = 0; t_fv = 0; last_cfc = 2'd0; last_frag = 3'd0;
   endtask

   task automatic drive_byte(input logic [7:0] b, input bit er);
      @(negedge clk); mii_rx_dv = 1'b1; mii_rxd = b[3:0]; mii_rx_er = 1'b0;
      @(negedge clk); mii_rxd = b[7:4]; mii_rx_er = er;
   endtask

   task automatic send(input int gap, input bit odd);
      build();
      zero_tallies();
      for (int i = 0; i < fb.size(); i++) drive_byte(fb[i], fe[i]);
      if (odd) begin @(negedge clk); mii_rxd = 4'hA; mii_rx_er = 1'b0; end
      @(negedge clk); mii_rx_dv = 1'b0; mii_rxd = 4'h0; mii_rx_er = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({r_rx_dv, r_rx_data, r_byte_ready, pream, smd_s, smd_c, smd_e,
                  smd_v, smd_r, smd_err, c_frame_cnt, rx_frag_cnt, frag_valid,
                  odd_nibble});
   endfunction

   initial begin
      zero_tallies();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", all_outs(), 32'd0);
      @(negedge clk); reset_n = 1'b1; chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // Preamble + SMD-E + 60 payload bytes
      clr(); pre(7); addb(8'hD5, 1'b0); data(60, 3); send(4, 1'b0);
      check("t1_strobes", t_strobe, 68);
      check("t1_pream", t_pream, 7);
      check("t1_smd_e", t_e, 1);
      check("t1_err", t_errf, 0);
      check("t1_rx_dv_cycles", t_dvhi, 136);

      // SMD-S2, then back-to-back SMD-C1 with fragment code 2
      clr(); pre(7); addb(8'h7F, 1'b0); data(5, 1); send(1, 1'b0);
      clr(); pre(7); addb(8'h52, 1'b0); addb(8'h7F, 1'b0); data(4, 9); send(4, 1'b0);
      check("t3_smd_c", t_c, 1);
      check("t3_cfc", last_cfc, 1);
      check("t3_frag_valid", t_fv, 1);
      check("t3_frag", last_frag, 2);

      // SMD-C3 followed by an invalid fragment code
      clr(); pre(3); addb(8'h2A, 1'b0); addb(8'h11, 1'b0); data(2, 5); send(4, 1'b0);
      check("t4_cfc", last_cfc, 3);
      check("t4_frag", last_frag, 4);
      check("t4_frag_valid", t_fv, 1);

      // Unknown SMD, then SMD-V and SMD-R
      clr(); pre(7); addb(8'h33, 1'b0); data(3, 2); send(4, 1'b0);
      check("t5_err", t_errf, 1);
      clr(); pre(2); addb(8'h07, 1'b0); data(2, 4); send(1, 1'b0);
      clr(); pre(1); addb(8'h19, 1'b0); send(4, 1'b0);
      check("t5_smd_r", t_r, 1);

      // rx_er on the high nibble of SMD-E
      clr(); pre(7); addb(8'hD5, 1'b1); data(3, 6); send(4, 1'b0);
      check("t6_err", t_errf, 1);
      check("t6_smd_e", t_e, 0);

      // Preamble overrun
      clr(); pre(16); data(3, 8); send(4, 1'b0);
      check("t7_pream", t_pream, 15);
      check("t7_err", t_errf, 1);

      // Odd-nibble frame end
      clr(); pre(2); addb(8'hD5, 1'b0); addb(8'h01, 1'b0); addb(8'h02, 1'b0); send(4, 1'b1);
      check("t8_strobes", t_strobe, 5);
      check("t8_odd_nibble", odd_nibble, 1);
      clr(); pre(1); addb(8'hD5, 1'b0); send(4, 1'b0);
      check("t9_odd_cleared", odd_nibble, 0);
      check("t9_strobes", t_strobe, 2);

      // Reset mid-frame, frame still running at release must be ignored
      chk_en = 1'b0;
      for (int i = 0; i < 3; i++) drive_byte(8'h55, 1'b0);
      @(negedge clk); mii_rx_dv = 1'b1; mii_rxd = 4'h5; reset_n = 1'b0;
      @(posedge clk); #1;
      check("midframe_reset_outputs", all_outs(), 32'd0);
      zero_tallies();
      @(negedge clk); mii_rxd = 4'h5; reset_n = 1'b1;
      for (int i = 0; i < 4; i++) drive_byte(8'hD5, 1'b0);
      @(negedge clk); mii_rx_dv = 1'b0; mii_rxd = 4'h0;
      repeat (5) @(negedge clk);
      check("ignored_strobes", t_strobe, 0);
      check("ignored_rx_dv", t_dvhi, 0);
      exp_q.delete();
      held = '0;
      chk_en = 1'b1;

      clr(); pre(7); addb(8'hD5, 1'b0); data(4, 11); send(4, 1'b0);
      check("t11_strobes", t_strobe, 12);
      check("t11_smd_e", t_e, 1);
      check("leftover_expected", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
